// File: rtl/rd_capture_sched.sv
// rd_capture_sched: replays read-command spacing from the gap FIFO as
// capture_en windows of BURST_CYC clocks. A train is anchored by burst_start.
// Each later window starts gap+1 cycles after the previous window started.
module rd_capture_sched #(
  parameter int BURST_CYC = 8,
  parameter int GAP_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [GAP_W:0]   fifo_rdata,
  output logic             fifo_rd_en,
  input  logic             burst_start,
  output logic             capture_en,
  output logic             capture_last,
  output logic             busy,
  output logic             sched_err,
  output logic [1:0]       sched_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int               BEAT_W    = 5;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_CYC - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [GAP_W-1:0]  SP_MAX    = {GAP_W{1'b1}};
  localparam logic [GAP_W-1:0]  SP_ZERO   = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]  SP_ONE    = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [BEAT_W-1:0]   beat_nxt_s;
  logic [GAP_W-1:0]    sp_r;
  logic [GAP_W-1:0]    sp_nxt_s;
  logic [GAP_W-1:0]    sp_inc_s;
  logic                err_r;
  logic                err_nxt_s;
  logic                pop_s;
  logic                cap_en_r;
  logic                cap_last_r;
  logic                head_ovf_s;
  logic [GAP_W-1:0]    head_gap_s;
  logic                launch_s;

  assign head_ovf_s = fifo_rdata[GAP_W];
  assign head_gap_s = fifo_rdata[GAP_W-1:0];

  // Spacing counter increment, saturating so very long gaps never alias.
  assign sp_inc_s = (sp_r == SP_MAX) ? sp_r : (sp_r + SP_ONE);

  // A valid non-overflow head whose gap matches the elapsed spacing starts
  // the next window on the following cycle.
  assign launch_s = ((state_r == ST_BURST) || (state_r == ST_GAP)) &&
                    !fifo_empty && !head_ovf_s && (sp_r == head_gap_s);

  // Next-state, counter and pop decisions.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    sp_nxt_s    = sp_r;
    err_nxt_s   = err_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        beat_nxt_s = BEAT_ZERO;
        sp_nxt_s   = SP_ZERO;
        // A preamble with no read outstanding is a protocol error.
        if (burst_start) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
        // First read of a train: its gap field carries no spacing info.
        if (!fifo_empty) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (burst_start) begin
          state_nxt_s = ST_BURST;
          beat_nxt_s  = BEAT_ZERO;
          sp_nxt_s    = SP_ZERO;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_BURST: begin
        sp_nxt_s = sp_inc_s;
        if (launch_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_BURST;
          beat_nxt_s  = BEAT_ZERO;
          sp_nxt_s    = SP_ZERO;
          // Launching before the last beat cuts the current window short.
          if (beat_r != BEAT_LAST) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end else if (beat_r == BEAT_LAST) begin
          state_nxt_s = ST_GAP;
          beat_nxt_s  = BEAT_ZERO;
        end else begin
          state_nxt_s = ST_BURST;
          beat_nxt_s  = beat_r + 5'd1;
        end
      end
      ST_GAP: begin
        sp_nxt_s   = sp_inc_s;
        beat_nxt_s = BEAT_ZERO;
        if (launch_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_BURST;
          sp_nxt_s    = SP_ZERO;
        end else if (!fifo_empty && head_ovf_s) begin
          // Spacing unknown: drop it and wait for the next preamble.
          pop_s       = 1'b1;
          state_nxt_s = ST_ARMED;
          sp_nxt_s    = SP_ZERO;
        end else if (!fifo_empty && (head_gap_s < sp_r)) begin
          // Entry arrived after its slot passed; resync on next preamble.
          pop_s       = 1'b1;
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_ARMED;
          sp_nxt_s    = SP_ZERO;
        end else if (fifo_empty && (sp_r == SP_MAX)) begin
          state_nxt_s = ST_IDLE;
          sp_nxt_s    = SP_ZERO;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        beat_nxt_s  = BEAT_ZERO;
        sp_nxt_s    = SP_ZERO;
      end
    endcase
  end

  // State, counters, sticky error and registered capture strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_r     <= BEAT_ZERO;
      sp_r       <= SP_ZERO;
      err_r      <= 1'b0;
      cap_en_r   <= 1'b0;
      cap_last_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_r     <= beat_nxt_s;
      sp_r       <= sp_nxt_s;
      err_r      <= err_nxt_s;
      cap_en_r   <= (state_nxt_s == ST_BURST);
      cap_last_r <= (state_nxt_s == ST_BURST) && (beat_nxt_s == BEAT_LAST);
    end
  end

  // The FIFO must not advance while the block is held in reset.
  assign fifo_rd_en   = pop_s & ~reset;
  assign capture_en   = cap_en_r;
  assign capture_last = cap_last_r;
  assign busy         = (state_r != ST_IDLE);
  assign sched_err    = err_r;
  assign sched_state  = state_r;

endmodule

// File: tb/tb_rd_capture_sched.sv
// tb_rd_capture_sched: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a timeline-based model.
module tb_rd_capture_sched;

  localparam int BC  = 8;
  localparam int SAT = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [5:0] fifo_rdata;
  logic       fifo_rd_en;
  logic       burst_start;
  logic       capture_en;
  logic       capture_last;
  logic       busy;
  logic       sched_err;
  logic [1:0] sched_state;

  rd_capture_sched #(.BURST_CYC(BC), .GAP_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd_en   (fifo_rd_en),
    .burst_start  (burst_start),
    .capture_en   (capture_en),
    .capture_last (capture_last),
    .busy         (busy),
    .sched_err    (sched_err),
    .sched_state  (sched_state)
  );

  always #5 clk = ~clk;

  logic [5:0] q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  pop_pending = 1'b0;

  // Model: mode 0 idle, 1 waiting for preamble, 2 train running.
  // age = cycles since the current window's first capture cycle.
  int  m_mode = 0;
  int  m_age  = 0;
  bit  m_err  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    if (q.size() == 0) fifo_rdata = 6'($urandom);
    else               fifo_rdata = q[0];
  endtask

  task automatic push(input logic [5:0] e);
    q.push_back(e);
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pending && q.size() > 0) q.delete(0);
    refresh();
    cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    burst_start = 1'b0;
    q.delete();
    refresh();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin : mon
    int sp;
    bit hv;
    bit hovf;
    int hgap;
    bit e_pop;
    int n_mode;
    int n_age;
    bit n_err;
    if (reset) begin
      chk("rst_capture_en", capture_en, 1'b0);
      chk("rst_capture_last", capture_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sched_err", sched_err, 1'b0);
      chk("rst_state", sched_state, 2'd0);
      chk("rst_fifo_rd_en", fifo_rd_en, 1'b0);
      m_mode = 0;
      m_age = 0;
      m_err = 1'b0;
      pop_pending = 1'b0;
    end else begin
      chk("m_capture_en", capture_en, (m_mode == 2) && (m_age < BC));
      chk("m_capture_last", capture_last, (m_mode == 2) && (m_age == BC - 1));
      chk("m_busy", busy, m_mode != 0);
      chk("m_sched_err", sched_err, m_err);
      chk("m_state", sched_state, (m_mode == 2) ? ((m_age < BC) ? 2 : 3) : m_mode);
      sp     = (m_age > SAT) ? SAT : m_age;
      hv     = !fifo_empty;
      hovf   = fifo_rdata[5];
      hgap   = int'(fifo_rdata[4:0]);
      e_pop  = 1'b0;
      n_mode = m_mode;
      n_age  = m_age;
      n_err  = m_err;
      case (m_mode)
        0: begin
          if (burst_start) n_err = 1'b1;
          if (hv) begin e_pop = 1'b1; n_mode = 1; end
        end
        1: begin
          if (burst_start) begin n_mode = 2; n_age = 0; end
        end
        default: begin
          if (hv && !hovf && hgap == sp) begin
            e_pop = 1'b1;
            if (m_age < BC - 1) n_err = 1'b1;
            n_age = 0;
          end else if (m_age >= BC && hv && hovf) begin
            e_pop = 1'b1; n_mode = 1;
          end else if (m_age >= BC && hv && hgap < sp) begin
            e_pop = 1'b1; n_err = 1'b1; n_mode = 1;
          end else if (m_age >= BC && !hv && sp == SAT) begin
            n_mode = 0;
          end else begin
            n_age = (m_age < 255) ? m_age + 1 : m_age;
          end
        end
      endcase
      chk("m_fifo_rd_en", fifo_rd_en, e_pop);
      pop_pending = fifo_rd_en;
      m_mode = n_mode;
      m_age  = n_age;
      m_err  = n_err;
    end
  end

  initial begin
    int qs;
    logic [5:0] e;
    reset       = 1'b1;
    burst_start = 1'b0;
    refresh();

    // Single read: window T+1..T+8, back to idle after sp saturates.
    do_reset();
    push(6'h00);
    tick(); tick();
    chk("t1_armed", sched_state, 2'd1);
    chk("t1_popped", q.size(), 0);
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("t1_en", capture_en, 1'b1);
      chk("t1_last", capture_last, k == 8);
      tick();
    end
    chk("t1_en_off", capture_en, 1'b0);
    chk("t1_gap_state", sched_state, 2'd3);
    repeat (23) tick();
    chk("t1_busy_t32", busy, 1'b1);
    tick();
    chk("t1_busy_t33", busy, 1'b0);

    // Back-to-back seamless windows.
    do_reset();
    push(6'h00); push(6'h07); push(6'h07);
    tick(); tick();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      chk("t2_en", capture_en, 1'b1);
      chk("t2_last", capture_last, (k % 8) == 0);
      tick();
    end
    chk("t2_en_off", capture_en, 1'b0);
    chk("t2_err", sched_err, 1'b0);

    // Spaced reads, gap 12.
    do_reset();
    push(6'h00); push(6'h0c);
    tick(); tick();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      chk("t3_en", capture_en, (k <= 8) || (k >= 14 && k <= 21));
      chk("t3_last", capture_last, (k == 8) || (k == 21));
      tick();
    end

    // Overflow resync.
    do_reset();
    push(6'h00); push(6'h3f);
    tick(); tick();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    repeat (11) tick();
    chk("t4_armed", sched_state, 2'd1);
    chk("t4_no_cap", capture_en, 1'b0);
    chk("t4_ovf_popped", q.size(), 0);
    push(6'h07);
    repeat (3) tick();
    chk("t4_held", q.size(), 1);
    chk("t4_still_armed", sched_state, 2'd1);
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("t4_en", capture_en, 1'b1);
      chk("t4_last", capture_last, (k == 8) || (k == 16));
      tick();
    end
    chk("t4_err", sched_err, 1'b0);

    // Overlap: gap 3 restarts the window at T+5.
    do_reset();
    push(6'h00); push(6'h03);
    tick(); tick();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk("t5_en", capture_en, k <= 12);
      chk("t5_last", capture_last, k == 12);
      chk("t5_err", sched_err, k >= 5);
      tick();
    end
    repeat (40) tick();
    chk("t5_err_sticky", sched_err, 1'b1);
    chk("t5_idle", busy, 1'b0);

    // Preamble while idle.
    do_reset();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    chk("t6_err", sched_err, 1'b1);
    chk("t6_idle", sched_state, 2'd0);
    repeat (5) tick();
    chk("t6_err_sticky", sched_err, 1'b1);

    // Reset at beat 3.
    do_reset();
    push(6'h00); push(6'h14);
    tick(); tick();
    burst_start = 1'b1; tick(); burst_start = 1'b0;
    tick(); tick(); tick();
    chk("t7_beat3_en", capture_en, 1'b1);
    qs = q.size();
    reset = 1'b1;
    #1;
    chk("t7_en", capture_en, 1'b0);
    chk("t7_last", capture_last, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_state", sched_state, 2'd0);
    chk("t7_rd_en", fifo_rd_en, 1'b0);
    repeat (4) tick();
    chk("t7_fifo_kept", q.size(), qs);
    chk("t7_fifo_one", qs, 1);
    reset = 1'b0;
    repeat (3) tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 12 && q.size() < 8) begin
        e[5] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 1) == 0) e[4:0] = 5'($urandom_range(0, 31));
        else                           e[4:0] = 5'($urandom_range(BC - 1, BC + 6));
        push(e);
      end
      burst_start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
      end
      tick();
    end
    burst_start = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
